// File: rtl/key_ctrl_pkg.sv
// Shared types and constants for the key-load controller.
package key_ctrl_pkg;

   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned KEY_W           = 16;
   localparam int unsigned CNT_W           = 8;
   localparam int unsigned TIMEOUT_DEFAULT = 15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RX_HI  = 2'd1,
      ST_RX_LO  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   typedef struct packed {
      logic [BYTE_W-1:0] hi;
      logic [BYTE_W-1:0] lo;
   } key_stage_t;

endpackage

// File: rtl/key_rr_arbiter.sv
// Two-way round-robin arbiter; priority moves past the winner on advance.
module key_rr_arbiter
   import key_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output req_id_t    grant
);

   req_id_t prio;

   always_comb begin
      grant = REQ_A;
      if (req[0] && req[1]) grant = prio;
      else if (req[1])      grant = REQ_B;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio <= REQ_A;
      end else if (advance) begin
         prio <= (grant == REQ_A) ? REQ_B : REQ_A;
      end
   end

endmodule

// File: rtl/key_load_ctrl.sv
// Arbitrates two byte-serial key sources and commits 16-bit keys to the key register.
module key_load_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [BYTE_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [BYTE_W-1:0] b_data,
   output logic              b_ready,
   input  logic              lock_req,
   output logic              key_load,
   output logic [KEY_W-1:0]  key_value,
   output logic              grant_b,
   output logic              busy,
   output logic              locked,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  load_count
);

   state_t            state;
   key_stage_t        stage;
   logic [CNT_W-1:0]  tmo_cnt;
   req_id_t           arb_grant;
   logic              start_c;
   logic              hs_c;
   logic              tmo_hit_c;
   logic [BYTE_W-1:0] hs_byte_c;

   assign start_c   = (state == ST_IDLE) && !locked && (a_valid || b_valid);
   assign hs_c      = grant_b ? (b_valid && b_ready) : (a_valid && a_ready);
   assign hs_byte_c = grant_b ? b_data : a_data;
   assign tmo_hit_c = (tmo_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT);

   // Priority is only consulted in IDLE, so moving it as the grant is taken
   // is indistinguishable from moving it when the transfer ends.
   key_rr_arbiter u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({b_valid, a_valid}),
      .advance (start_c),
      .grant   (arb_grant)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         stage      <= '0;
         tmo_cnt    <= '0;
         key_value  <= '0;
         load_count <= '0;
         locked     <= 1'b0;
         grant_b    <= 1'b0;
         busy       <= 1'b0;
         a_ready    <= 1'b0;
         b_ready    <= 1'b0;
         key_load   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         key_load <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         if (lock_req) locked <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (start_c) begin
                  state   <= ST_RX_HI;
                  busy    <= 1'b1;
                  grant_b <= (arb_grant == REQ_B);
                  a_ready <= (arb_grant == REQ_A);
                  b_ready <= (arb_grant == REQ_B);
                  tmo_cnt <= '0;
               end
            end

            ST_RX_HI, ST_RX_LO: begin
               if (hs_c) begin
                  tmo_cnt <= '0;
                  if (state == ST_RX_HI) begin
                     stage.hi <= hs_byte_c;
                     state    <= ST_RX_LO;
                  end else begin
                     stage.lo  <= hs_byte_c;
                     key_value <= {stage.hi, hs_byte_c};
                     key_load  <= 1'b1;
                     done      <= 1'b1;
                     a_ready   <= 1'b0;
                     b_ready   <= 1'b0;
                     state     <= ST_COMMIT;
                  end
               end else if (tmo_hit_c) begin
                  // Abort: drop the partial key, key_value is left untouched.
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  err     <= 1'b1;
                  a_ready <= 1'b0;
                  b_ready <= 1'b0;
                  stage   <= '0;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end

            ST_COMMIT: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               if (load_count != '1) load_count <= load_count + CNT_W'(1);
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Self-checking bench for key_load_ctrl: vector table, directed corners, random vs. model.
module tb_key_load_ctrl;
   import key_ctrl_pkg::*;

   localparam int unsigned TMO = 15;

   logic        clk, reset;
   logic        a_valid, b_valid, lock_req;
   logic [7:0]  a_data, b_data;
   logic        a_ready, b_ready, key_load, grant_b, busy, locked, done, err;
   logic [15:0] key_value;
   logic [7:0]  load_count;

   int tests = 0;
   int fails = 0;

   key_load_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .lock_req(lock_req), .key_load(key_load), .key_value(key_value),
      .grant_b(grant_b), .busy(busy), .locked(locked), .done(done),
      .err(err), .load_count(load_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level reference: owner (-1 none, 0 A, 1 B), bytes seen, idle run
   int          m_owner, m_bytes, m_idle, m_count;
   bit          m_commit, m_prio, m_locked, m_gnt, m_load, m_err;
   logic [7:0]  m_hi;
   logic [15:0] m_key;

   function automatic void model_reset();
      m_owner = -1; m_bytes = 0; m_idle = 0; m_count = 0;
      m_commit = 0; m_prio = 0; m_locked = 0; m_gnt = 0; m_load = 0; m_err = 0;
      m_hi = '0; m_key = '0;
   endfunction

   function automatic void model_edge();
      int w;
      bit v;
      logic [7:0] d;
      m_load = 0; m_err = 0;
      if (m_owner < 0) begin
         if (!m_locked && (a_valid || b_valid)) begin
            w = (a_valid && b_valid) ? int'(m_prio) : (b_valid ? 1 : 0);
            m_owner = w; m_gnt = (w == 1); m_prio = (w == 0);
            m_bytes = 0; m_idle = 0;
         end
      end else if (m_commit) begin
         m_owner = -1; m_commit = 0;
         if (m_count < 255) m_count++;
      end else begin
         v = (m_owner == 1) ? b_valid : a_valid;
         d = (m_owner == 1) ? b_data : a_data;
         if (v) begin
            m_idle = 0;
            if (m_bytes == 0) begin m_hi = d; m_bytes = 1; end
            else begin m_key = {m_hi, d}; m_commit = 1; m_load = 1; end
         end else begin
            m_idle++;
            if (m_idle == int'(TMO)) begin m_owner = -1; m_err = 1; end
         end
      end
      if (lock_req) m_locked = 1;
   endfunction

   function automatic logic [31:0] model_out();
      return {(m_owner == 0) && !m_commit, (m_owner == 1) && !m_commit, m_owner >= 0,
              m_load, m_load, m_err, m_gnt, m_locked, m_key, 8'(m_count)};
   endfunction

   function automatic logic [31:0] dut_out();
      return {a_ready, b_ready, busy, key_load, done, err, grant_b, locked, key_value, load_count};
   endfunction

   function automatic logic [31:0] mk(bit ar, bit br, bit bz, bit kl, bit er, bit gb, bit lk,
                                      logic [15:0] kv, logic [7:0] lc);
      return {ar, br, bz, kl, kl, er, gb, lk, kv, lc};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      model_reset();
      reset = 1'b0;
   endtask

   task automatic idle_inputs();
      a_valid = 0; b_valid = 0; lock_req = 0; a_data = '0; b_data = '0;
   endtask

   typedef struct {
      bit          rst;
      bit          av;
      logic [7:0]  ad;
      bit          bv;
      logic [7:0]  bd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, input bit av, input logic [7:0] ad,
                      input bit bv, input logic [7:0] bd, input logic [31:0] exp);
      vec_t v;
      v.rst = rst; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.exp = exp;
      vecs.push_back(v);
   endtask

   initial begin
      int cyc, loads, pa, pb;
      bit seen_load, any_rdy;

      reset = 1'b0;
      idle_inputs();

      // Columns of mk: a_ready b_ready busy key_load err grant_b locked key_value load_count
      add(1, 0, 8'h00, 0, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
      add(0, 1, 8'hA5, 0, 8'h00, mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 0));
      add(0, 1, 8'hA5, 0, 8'h00, mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 0));
      add(0, 1, 8'h3C, 0, 8'h00, mk(0, 0, 1, 1, 0, 0, 0, 16'hA53C, 0));
      add(0, 0, 8'h00, 0, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 16'hA53C, 1));
      add(1, 0, 8'h00, 0, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
      add(0, 1, 8'h11, 1, 8'h12, mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 0));
      add(0, 1, 8'h11, 1, 8'h12, mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 0));
      add(0, 1, 8'h22, 1, 8'h12, mk(0, 0, 1, 1, 0, 0, 0, 16'h1122, 0));
      add(0, 0, 8'h00, 1, 8'h12, mk(0, 0, 0, 0, 0, 0, 0, 16'h1122, 1));
      add(0, 0, 8'h00, 1, 8'h12, mk(0, 1, 1, 0, 0, 1, 0, 16'h1122, 1));
      add(0, 0, 8'h00, 1, 8'h12, mk(0, 1, 1, 0, 0, 1, 0, 16'h1122, 1));
      add(0, 0, 8'h00, 1, 8'h34, mk(0, 0, 1, 1, 0, 1, 0, 16'h1234, 1));
      add(0, 0, 8'h00, 0, 8'h00, mk(0, 0, 0, 0, 0, 1, 0, 16'h1234, 2));

      #1;
      foreach (vecs[i]) begin
         if (vecs[i].rst) begin
            idle_inputs();
            reset = 1'b1;
            #1;
            check($sformatf("vec%0d_reset", i), dut_out(), vecs[i].exp);
            #1;
            model_reset();
            reset = 1'b0;
         end else begin
            a_valid = vecs[i].av; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_data = vecs[i].bd;
            step();
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
         end
      end
      idle_inputs();

      // B sends one byte then goes silent; priority now back at A
      b_valid = 1; b_data = 8'h77;
      step();
      check("tmo_grant_b", {grant_b, b_ready, a_ready}, 3'b110);
      step();
      b_valid = 0;
      cyc = 0; seen_load = 0;
      while (!err && cyc < 40) begin
         step();
         cyc++;
         if (key_load) seen_load = 1;
      end
      check("tmo_cycles", 32'(cyc), 32'd15);
      check("tmo_noload", 32'(seen_load), 32'd0);
      check("tmo_key_busy", {busy, key_value}, {1'b0, 16'h1234});
      check("tmo_model", dut_out(), model_out());

      // Both request after the abort: A must win
      a_valid = 1; a_data = 8'hBE; b_valid = 1; b_data = 8'h55;
      step();
      check("rr_after_abort", {grant_b, a_ready, b_ready}, 3'b010);
      step();
      a_valid = 0; lock_req = 1;
      step();
      lock_req = 0;
      check("lock_mid_xfer", {locked, busy, a_ready, b_ready}, 4'b1110);
      a_valid = 1; a_data = 8'hEF;
      step();
      check("lock_commit", {key_load, done, key_value}, {2'b11, 16'hBEEF});
      step();
      check("lock_count", 32'(load_count), 32'd3);
      any_rdy = 0;
      for (int i = 0; i < 30; i++) begin
         a_data = 8'(i); b_data = 8'(i + 1);
         step();
         if (a_ready || b_ready || busy || key_load) any_rdy = 1;
      end
      check("locked_no_grant", {any_rdy, locked}, 2'b01);
      check("locked_model", dut_out(), model_out());
      idle_inputs();

      // Reset between the high and low byte
      do_reset();
      a_valid = 1; a_data = 8'hC3;
      step();
      step();
      a_valid = 0;
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid", {busy, key_load, err, a_ready, key_value}, 20'h0);
      model_reset();
      reset = 1'b0;
      seen_load = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (key_load || err || busy) seen_load = 1;
      end
      check("rst_mid_quiet", {seen_load, key_value, load_count}, 25'h0);

      // 260 back-to-back commits
      do_reset();
      a_valid = 1;
      loads = 0; cyc = 0;
      while (loads < 260 && cyc < 2000) begin
         a_data = 8'($urandom);
         step();
         cyc++;
         if (key_load) loads++;
      end
      check("sat_loads", 32'(loads), 32'd260);
      a_valid = 0;
      step();
      step();
      check("sat_count", 32'(load_count), 32'd255);
      check("sat_model", dut_out(), model_out());

      // Random traffic against the model
      pa = 0; pb = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) begin
            idle_inputs();
            do_reset();
         end
         if (i % 32 == 0) begin
            pa = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 50 : 90);
            pb = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 50 : 90);
         end
         a_valid  = ($urandom_range(0, 99) < pa);
         b_valid  = ($urandom_range(0, 99) < pb);
         a_data   = 8'($urandom);
         b_data   = 8'($urandom);
         lock_req = ($urandom_range(0, 399) == 0);
         step();
         check($sformatf("rand%0d", i), dut_out(), model_out());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
